// File: rtl/ex_hazard_ctrl_pkg.sv
// Shared types for the Execute-stage hazard controller.
//   reg_addr_t  : architectural register index
//   fwd_sel_t   : ALU operand source select
//   stage_tag_t : per-stage bookkeeping (destination, write/load flags, EX sources)
//   tag_match() : "this stage will write register r" test; X31 never matches
package ex_hazard_ctrl_pkg;

  localparam int unsigned REG_AW    = 5;
  localparam int unsigned ZERO_REG  = 31;
  localparam int unsigned CNT_W_DEF = 16;

  typedef logic [REG_AW-1:0] reg_addr_t;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic      valid;
    reg_addr_t rd;
    logic      reg_write;
    logic      mem_read;
    reg_addr_t rn;
    reg_addr_t rm;
    logic      rn_used;
    logic      rm_used;
  } stage_tag_t;

  localparam stage_tag_t TAG_NONE = '0;

  // True when the stage holds a live write to r; the zero register never matches.
  function automatic logic tag_match(input stage_tag_t t, input reg_addr_t r);
    return t.valid & t.reg_write & (t.rd == r) & (r != REG_AW'(ZERO_REG));
  endfunction

endpackage

// File: rtl/ex_hazard_ctrl_if.sv
// Decode-side request and pipeline-control response bundle for ex_hazard_ctrl.
//   master : pipeline side (drives decode info and flush, consumes controls)
//   slave  : hazard controller side
interface ex_hazard_ctrl_if
  import ex_hazard_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
);

  logic             id_valid;
  reg_addr_t        id_rn;
  reg_addr_t        id_rm;
  logic             id_rn_used;
  logic             id_rm_used;
  reg_addr_t        id_rd;
  logic             id_reg_write;
  logic             id_mem_read;
  logic             flush;

  fwd_sel_t         fwd_a;
  fwd_sel_t         fwd_b;
  logic             stall_if;
  logic             stall_id;
  logic             bubble_ex;
  logic             flush_id;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_valid, id_rn, id_rm, id_rn_used, id_rm_used,
           id_rd, id_reg_write, id_mem_read, flush,
    input  fwd_a, fwd_b, stall_if, stall_id, bubble_ex, flush_id, stall_count
  );

  modport slave (
    input  id_valid, id_rn, id_rm, id_rn_used, id_rm_used,
           id_rd, id_reg_write, id_mem_read, flush,
    output fwd_a, fwd_b, stall_if, stall_id, bubble_ex, flush_id, stall_count
  );

endinterface

// File: rtl/ex_hazard_ctrl_pipe_tag_reg.sv
// One pipeline stage's tag register.
//   clk, reset : clock, async active-low reset (clears to an invalid tag)
//   clr_i      : synchronous clear, loads an invalid tag (bubble)
//   d_i / q_o  : next / current stage tag
module ex_hazard_ctrl_pipe_tag_reg
  import ex_hazard_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr_i,
  input  stage_tag_t d_i,
  output stage_tag_t q_o
);

  stage_tag_t tag_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_q <= TAG_NONE;
    end else if (clr_i) begin
      tag_q <= TAG_NONE;
    end else begin
      tag_q <= d_i;
    end
  end

  assign q_o = tag_q;

endmodule

// File: rtl/ex_hazard_ctrl.sv
// Execute-stage hazard controller: tracks EX/MEM/WB destination tags, picks
// ALU operand forwarding, stalls one cycle on load-use and bubbles on flush.
//   clk, reset : clock, async active-low reset
//   hz         : slave side of ex_hazard_ctrl_if
//                in : id_* decode info, flush
//                out: fwd_a/fwd_b, stall_if/stall_id, bubble_ex, flush_id
//                     (combinational), stall_count (registered, saturating)
module ex_hazard_ctrl
  import ex_hazard_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  ex_hazard_ctrl_if.slave   hz
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  stage_tag_t       id_tag_c;
  stage_tag_t       ex_q;
  stage_tag_t       mem_q;
  stage_tag_t       wb_q;

  logic             load_use_c;
  logic             ex_clr_c;
  fwd_sel_t         fwd_a_c;
  fwd_sel_t         fwd_b_c;
  logic             stall_if_c;
  logic             stall_id_c;
  logic             bubble_ex_c;
  logic             flush_id_c;

  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;

  // Operand source: MEM beats WB; nothing forwarded for an empty EX slot or unread operand.
  function automatic fwd_sel_t fwd_pick(input stage_tag_t mem_t, input stage_tag_t wb_t,
                                        input logic ex_valid, input logic used,
                                        input reg_addr_t r);
    if (!(ex_valid && used)) return FWD_REG;
    if (tag_match(mem_t, r)) return FWD_MEM;
    if (tag_match(wb_t, r))  return FWD_WB;
    return FWD_REG;
  endfunction

  // Decode instruction packed into a tag for entry into EX.
  always_comb begin
    id_tag_c           = TAG_NONE;
    id_tag_c.valid     = hz.id_valid;
    id_tag_c.rd        = hz.id_rd;
    id_tag_c.reg_write = hz.id_reg_write;
    id_tag_c.mem_read  = hz.id_mem_read;
    id_tag_c.rn        = hz.id_rn;
    id_tag_c.rm        = hz.id_rm;
    id_tag_c.rn_used   = hz.id_rn_used;
    id_tag_c.rm_used   = hz.id_rm_used;
  end

  // Load in EX whose result the decode instruction needs this cycle.
  always_comb begin
    load_use_c = hz.id_valid & ex_q.mem_read &
                 ((tag_match(ex_q, hz.id_rn) & hz.id_rn_used) |
                  (tag_match(ex_q, hz.id_rm) & hz.id_rm_used));
  end

  // Pipeline controls; flush wins over load-use and suppresses the stall.
  always_comb begin
    stall_if_c  = 1'b0;
    stall_id_c  = 1'b0;
    bubble_ex_c = 1'b0;
    flush_id_c  = 1'b0;
    if (hz.flush) begin
      flush_id_c  = 1'b1;
      bubble_ex_c = 1'b1;
    end else if (load_use_c) begin
      stall_if_c  = 1'b1;
      stall_id_c  = 1'b1;
      bubble_ex_c = 1'b1;
    end
  end

  assign ex_clr_c = bubble_ex_c;

  always_comb begin
    fwd_a_c = fwd_pick(mem_q, wb_q, ex_q.valid, ex_q.rn_used, ex_q.rn);
    fwd_b_c = fwd_pick(mem_q, wb_q, ex_q.valid, ex_q.rm_used, ex_q.rm);
  end

  ex_hazard_ctrl_pipe_tag_reg u_ex_tag (
    .clk   (clk),
    .reset (reset),
    .clr_i (ex_clr_c),
    .d_i   (id_tag_c),
    .q_o   (ex_q)
  );

  ex_hazard_ctrl_pipe_tag_reg u_mem_tag (
    .clk   (clk),
    .reset (reset),
    .clr_i (1'b0),
    .d_i   (ex_q),
    .q_o   (mem_q)
  );

  ex_hazard_ctrl_pipe_tag_reg u_wb_tag (
    .clk   (clk),
    .reset (reset),
    .clr_i (1'b0),
    .d_i   (mem_q),
    .q_o   (wb_q)
  );

  // Saturating count of stall cycles actually taken (flushed ones excluded).
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_if_c && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // WB source/load fields leave the pipeline here without a consumer.
  logic unused_wb_c;
  assign unused_wb_c = ^{wb_q.mem_read, wb_q.rn, wb_q.rm, wb_q.rn_used, wb_q.rm_used};

  assign hz.fwd_a       = fwd_a_c;
  assign hz.fwd_b       = fwd_b_c;
  assign hz.stall_if    = stall_if_c;
  assign hz.stall_id    = stall_id_c;
  assign hz.bubble_ex   = bubble_ex_c;
  assign hz.flush_id    = flush_id_c;
  assign hz.stall_count = stall_cnt_q;

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Directed bench for ex_hazard_ctrl: forwarding, load-use stall, flush,
// zero-register handling, async reset, and counter saturation (narrow instance).
module tb_ex_hazard_ctrl;
  import ex_hazard_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ex_hazard_ctrl_if #(.CNT_W(16)) hz ();
  ex_hazard_ctrl_if #(.CNT_W(2))  hz_s ();

  ex_hazard_ctrl #(.CNT_W(16)) u_dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  ex_hazard_ctrl #(.CNT_W(2)) u_sat (
    .clk   (clk),
    .reset (reset),
    .hz    (hz_s)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rn, input logic rnu,
                        input logic [4:0] rm, input logic rmu,
                        input logic [4:0] rd, input logic rw, input logic mr);
    hz.id_valid     = v;
    hz.id_rn        = rn;
    hz.id_rn_used   = rnu;
    hz.id_rm        = rm;
    hz.id_rm_used   = rmu;
    hz.id_rd        = rd;
    hz.id_reg_write = rw;
    hz.id_mem_read  = mr;
  endtask

  task automatic idle();
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    hz.flush = 1'b0;
  endtask

  task automatic drain();
    idle();
    repeat (3) tick();
  endtask

  task automatic set_sat(input logic v, input logic [4:0] rm, input logic rmu,
                         input logic [4:0] rd, input logic rw, input logic mr);
    hz_s.id_valid     = v;
    hz_s.id_rn        = 5'd2;
    hz_s.id_rn_used   = 1'b0;
    hz_s.id_rm        = rm;
    hz_s.id_rm_used   = rmu;
    hz_s.id_rd        = rd;
    hz_s.id_reg_write = rw;
    hz_s.id_mem_read  = mr;
    hz_s.flush        = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    idle();
    set_sat(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    repeat (2) tick();
    settle();

    // Reset state
    check("rst_fwd_a",    32'(hz.fwd_a), 32'd0);
    check("rst_fwd_b",    32'(hz.fwd_b), 32'd0);
    check("rst_stall_if", 32'(hz.stall_if), 32'd0);
    check("rst_stall_id", 32'(hz.stall_id), 32'd0);
    check("rst_bubble",   32'(hz.bubble_ex), 32'd0);
    check("rst_flush_id", 32'(hz.flush_id), 32'd0);
    check("rst_count",    32'(hz.stall_count), 32'd0);
    reset = 1'b1;
    tick();

    // Back-to-back ALU dependency: forward from MEM
    set_id(1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 5'd1, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd4, 1'b1, 1'b0);
    settle();
    check("alu_nostall", 32'(hz.stall_if), 32'd0);
    tick();
    idle();
    settle();
    check("b2b_fwd_a", 32'(hz.fwd_a), 32'd1);
    check("b2b_fwd_b", 32'(hz.fwd_b), 32'd0);
    drain();

    // Producer two ahead: forward from WB
    set_id(1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 5'd1, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 5'd8, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd1, 1'b1, 5'd9, 1'b1, 5'd10, 1'b1, 1'b0);
    tick();
    idle();
    settle();
    check("wb_fwd_a", 32'(hz.fwd_a), 32'd2);
    check("wb_fwd_b", 32'(hz.fwd_b), 32'd0);
    drain();

    // Same reg in MEM and WB: MEM wins; unread rm never forwards
    set_id(1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 5'd1, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 5'd1, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd1, 1'b1, 5'd1, 1'b0, 5'd11, 1'b1, 1'b0);
    tick();
    idle();
    settle();
    check("prio_fwd_a",   32'(hz.fwd_a), 32'd1);
    check("unused_fwd_b", 32'(hz.fwd_b), 32'd0);
    drain();

    // Load-use on rm: one stall cycle, then forward from WB
    set_id(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd7, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0);
    settle();
    check("lu_stall_if", 32'(hz.stall_if), 32'd1);
    check("lu_stall_id", 32'(hz.stall_id), 32'd1);
    check("lu_bubble",   32'(hz.bubble_ex), 32'd1);
    check("lu_flush_id", 32'(hz.flush_id), 32'd0);
    tick();
    settle();
    check("lu2_stall_if", 32'(hz.stall_if), 32'd0);
    check("lu2_bubble",   32'(hz.bubble_ex), 32'd0);
    check("lu_count",     32'(hz.stall_count), 32'd1);
    tick();
    idle();
    settle();
    check("lu_fwd_b", 32'(hz.fwd_b), 32'd2);
    check("lu_fwd_a", 32'(hz.fwd_a), 32'd0);
    drain();

    // Load-use coinciding with flush: flush wins, no count
    set_id(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd7, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0);
    hz.flush = 1'b1;
    settle();
    check("fl_flush_id", 32'(hz.flush_id), 32'd1);
    check("fl_bubble",   32'(hz.bubble_ex), 32'd1);
    check("fl_stall_if", 32'(hz.stall_if), 32'd0);
    check("fl_stall_id", 32'(hz.stall_id), 32'd0);
    tick();
    idle();
    settle();
    check("fl_count", 32'(hz.stall_count), 32'd1);
    check("fl_fwd_b", 32'(hz.fwd_b), 32'd0);
    drain();

    // Load result not actually read (rm_used=0): no stall
    set_id(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd7, 1'b1, 5'd5, 1'b0, 5'd6, 1'b1, 1'b0);
    settle();
    check("nouse_stall", 32'(hz.stall_if), 32'd0);
    drain();

    // Zero register: never forwarded, never stalls
    set_id(1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 5'd31, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd31, 1'b1, 5'd31, 1'b1, 5'd12, 1'b1, 1'b0);
    tick();
    idle();
    settle();
    check("zr_fwd_a", 32'(hz.fwd_a), 32'd0);
    check("zr_fwd_b", 32'(hz.fwd_b), 32'd0);
    drain();
    set_id(1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 5'd31, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd31, 1'b1, 5'd31, 1'b1, 5'd13, 1'b1, 1'b0);
    settle();
    check("zr_stall_if", 32'(hz.stall_if), 32'd0);
    check("zr_bubble",   32'(hz.bubble_ex), 32'd0);
    tick();
    drain();
    check("zr_count", 32'(hz.stall_count), 32'd1);

    // Mid-run reset with a live load-use pending
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd14, 1'b1, 1'b0);
    settle();
    check("pre_rst_stall", 32'(hz.stall_if), 32'd1);
    #1 reset = 1'b0;
    #1;
    check("mrst_stall_if", 32'(hz.stall_if), 32'd0);
    check("mrst_stall_id", 32'(hz.stall_id), 32'd0);
    check("mrst_bubble",   32'(hz.bubble_ex), 32'd0);
    check("mrst_count",    32'(hz.stall_count), 32'd0);
    check("mrst_fwd_a",    32'(hz.fwd_a), 32'd0);
    tick();
    reset = 1'b1;
    settle();
    check("post_rst_stall", 32'(hz.stall_if), 32'd0);
    tick();
    drain();

    // Saturation on the 2-bit counter instance (max 3)
    for (int i = 0; i < 5; i++) begin
      set_sat(1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
      tick();
      set_sat(1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0);
      settle();
      check("sat_stall", 32'(hz_s.stall_if), 32'd1);
      tick();
      set_sat(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      settle();
      check("sat_count", 32'(hz_s.stall_count), (i < 3) ? 32'(i + 1) : 32'd3);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
